// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: PC, credit-limited memory requests, 2-entry
// instruction buffer toward decode, and redirect handling with stale-fetch kill.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        arst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    logic [31:0] r_pc;
    logic [1:0]  r_out_cnt;
    logic [1:0]  r_kill_cnt;
    logic [1:0]  r_buf_cnt;
    logic        r_buf_rd;
    logic        r_buf_wr;
    logic        r_aq_rd;
    logic        r_aq_wr;
    logic [31:0] r_buf_instr [2];
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_aq_pc     [2];

    logic        w_req_fire;
    logic        w_rsp_fire;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_credit;
    logic [1:0]  w_out_nxt;

    function automatic logic [1:0] sat2(input logic [2:0] v);
        return (v > 3'd2) ? 2'd2 : v[1:0];
    endfunction

    // Outstanding + buffered never exceeds 2, so every response has a free slot.
    assign w_credit       = {1'b0, r_out_cnt} + {1'b0, r_buf_cnt};
    assign imem_req_valid = !arst && (w_credit < 3'd2);
    assign imem_req_addr  = r_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_fire = imem_rsp_valid && (r_out_cnt != 2'd0);
    assign w_push     = w_rsp_fire && (r_kill_cnt == 2'd0) && !redirect_valid;
    assign w_pop      = instr_valid && instr_ready;
    assign w_out_nxt  = sat2({1'b0, r_out_cnt} + {2'b00, w_req_fire} - {2'b00, w_rsp_fire});

    assign instr_valid = (r_buf_cnt != 2'd0);
    assign instr       = instr_valid ? r_buf_instr[r_buf_rd] : 32'h0000_0000;
    assign instr_pc    = instr_valid ? r_buf_pc[r_buf_rd]    : 32'h0000_0000;
    assign opcode      = instr[31:26];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pc       <= PC_RESET;
            r_out_cnt  <= 2'd0;
            r_kill_cnt <= 2'd0;
            r_buf_cnt  <= 2'd0;
            r_buf_rd   <= 1'b0;
            r_buf_wr   <= 1'b0;
            r_aq_rd    <= 1'b0;
            r_aq_wr    <= 1'b0;
        end else begin
            r_out_cnt <= w_out_nxt;
            if (w_req_fire) r_aq_wr <= ~r_aq_wr;
            if (w_rsp_fire) r_aq_rd <= ~r_aq_rd;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old stream.
                r_pc       <= redirect_pc;
                r_kill_cnt <= w_out_nxt;
                r_buf_cnt  <= 2'd0;
                r_buf_rd   <= 1'b0;
                r_buf_wr   <= 1'b0;
            end else begin
                if (w_req_fire) r_pc <= r_pc + 32'd4;
                if (w_rsp_fire && (r_kill_cnt != 2'd0)) r_kill_cnt <= r_kill_cnt - 2'd1;
                if (w_push) r_buf_wr <= ~r_buf_wr;
                if (w_pop)  r_buf_rd <= ~r_buf_rd;
                r_buf_cnt <= r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (w_req_fire) r_aq_pc[r_aq_wr] <= r_pc;
        if (w_push) begin
            r_buf_instr[r_buf_wr] <= imem_rsp_data;
            r_buf_pc[r_buf_wr]    <= r_aq_pc[r_aq_rd];
        end
    end

endmodule
